// File: rtl/inst_rr_scheduler_if.sv
// inst_rr_scheduler_if: request/release inputs and registered grant outputs of inst_rr_scheduler
interface inst_rr_scheduler_if #(parameter int NUM_REQ = 5);
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] done;
   logic [NUM_REQ-1:0] gnt;
   logic [2:0]         gnt_id;
   logic               busy;
   logic               timeout_err;
   modport master (output req, done, input gnt, gnt_id, busy, timeout_err);
   modport slave (input req, done, output gnt, gnt_id, busy, timeout_err);
endinterface

// File: rtl/inst_rr_scheduler.sv
// inst_rr_scheduler: round-robin single-grant scheduler; optional watchdog via INST_RR_SCHEDULER_TIMEOUT_EN
module inst_rr_scheduler #(
   parameter int NUM_REQ = 5,
   parameter int TIMEOUT = 16
) (
   input logic                clk,
   input logic                rst,
   inst_rr_scheduler_if.slave bus
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;
   logic [0:0] state;
   logic [2:0] ptr;
   logic [2:0] win;
   logic       rel;
   logic       expire;
   // scan backwards so the requester closest to ptr is the last (winning) assignment
   always_comb begin
      win = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (bus.req[(int'(ptr) + k) % NUM_REQ]) win = 3'((int'(ptr) + k) % NUM_REQ);
   end
   assign rel = |(bus.gnt & (bus.done | ~bus.req));
`ifdef INST_RR_SCHEDULER_TIMEOUT_EN
   logic [7:0] cnt;
   assign expire = cnt == 8'(TIMEOUT - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= (state == BUSY) ? cnt + 8'd1 : '0;
`else
   assign expire = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         bus.gnt         <= '0;
         bus.gnt_id      <= '0;
         bus.busy        <= 1'b0;
         bus.timeout_err <= 1'b0;
         ptr             <= '0;
      end else if (state == IDLE) begin
         bus.timeout_err <= 1'b0;
         if (|bus.req) begin
            state      <= BUSY;
            bus.gnt    <= NUM_REQ'(1) << win;
            bus.gnt_id <= win;
            bus.busy   <= 1'b1;
         end
      end else if (rel || expire) begin
         state           <= IDLE;
         bus.gnt         <= '0;
         bus.gnt_id      <= '0;
         bus.busy        <= 1'b0;
         bus.timeout_err <= expire & ~rel;
         ptr             <= (bus.gnt_id == 3'(NUM_REQ - 1)) ? 3'd0 : bus.gnt_id + 3'd1;
      end else begin
         bus.timeout_err <= 1'b0;
      end
   end
endmodule
